// File: rtl/dtw_core_batch.sv
// Batch controller for a DTW datapath: loads a reference into memory, then streams queries and emits
// one {qid, position, minval} record per query. Optional threshold rejection via DTW_THRESH_REJECT_EN.
module dtw_core_batch #(
  parameter int WIDTH            = 16,
  parameter int AXIS_WIDTH       = 32,
  parameter int SQG_SIZE         = 256,
  parameter int REFMEM_PTR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rs,
  input  logic [AXIS_WIDTH-1:0]       ref_len,
  input  logic [31:0]                 num_queries,
  input  logic [WIDTH-1:0]            threshold,
  output logic                        busy,
  output logic                        load_done,
  output logic [31:0]                 n_done,
  output logic [31:0]                 n_reject,
  output logic                        src_fifo_clear,
  output logic                        src_fifo_rden,
  input  logic                        src_fifo_empty,
  input  logic [31:0]                 src_fifo_data,
  output logic                        sink_fifo_wren,
  input  logic                        sink_fifo_full,
  output logic [31:0]                 sink_fifo_data,
  output logic                        sink_fifo_last,
  output logic                        ref_wen,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr,
  output logic [WIDTH-1:0]            ref_din,
  output logic                        dp_rst,
  output logic                        dp_running,
  input  logic                        dp_done,
  input  logic [WIDTH-1:0]            dp_minval,
  input  logic [31:0]                 dp_position
);

  localparam int SCW = $clog2(SQG_SIZE + 1);

  typedef enum logic [2:0] {IDLE, REF_LOAD, Q_INIT, Q_RUN, Q_OUT} state_e;

  state_e                      state_q, state_d;
  logic [AXIS_WIDTH-1:0]       load_cnt_q, load_cnt_d;
  logic [REFMEM_PTR_WIDTH-1:0] ref_addr_q, ref_addr_d;
  logic [SCW-1:0]              samp_cnt_q, samp_cnt_d;
  logic [31:0]                 qid_q, qid_d;
  logic [31:0]                 pos_q, pos_d;
  logic [WIDTH-1:0]            min_q, min_d;
  logic [1:0]                  word_q, word_d;
  logic                        init_first_q, init_first_d;
  logic                        load_done_q, load_done_d;
  logic [31:0]                 n_done_q, n_done_d;
  logic                        finish;
  logic                        emit_rec;
  logic                        run_tail;
  logic [31:0]                 n_done_inc;
  logic                        is_final;

  assign n_done_inc = n_done_q + 32'd1;
  assign is_final   = (num_queries != 32'd0) && (n_done_inc == num_queries);
  assign run_tail   = (samp_cnt_q == SCW'(SQG_SIZE));
  assign load_done  = load_done_q;
  assign n_done     = n_done_q;

  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    ref_addr_d     = ref_addr_q;
    samp_cnt_d     = samp_cnt_q;
    qid_d          = qid_q;
    pos_d          = pos_q;
    min_d          = min_q;
    word_d         = word_q;
    init_first_d   = init_first_q;
    load_done_d    = load_done_q;
    n_done_d       = n_done_q;
    finish         = 1'b0;
    busy           = (state_q != IDLE);
    src_fifo_clear = 1'b0;
    src_fifo_rden  = 1'b0;
    sink_fifo_wren = 1'b0;
    sink_fifo_data = '0;
    sink_fifo_last = 1'b0;
    ref_wen        = 1'b0;
    ref_addr       = ref_addr_q;
    ref_din        = '0;
    dp_rst         = 1'b0;
    dp_running     = 1'b0;

    case (state_q)
      IDLE: begin
        src_fifo_clear = 1'b1;
        dp_rst         = 1'b1;
        ref_addr_d     = '0;
        if (rs) begin
          state_d    = REF_LOAD;
          load_cnt_d = '0;
          n_done_d   = '0;
        end
      end
      REF_LOAD: begin
        ref_addr = REFMEM_PTR_WIDTH'(load_cnt_q);
        if (load_cnt_q == ref_len) begin
          load_done_d  = 1'b1;
          state_d      = Q_INIT;
          init_first_d = 1'b1;
          ref_addr_d   = '0;
        end else begin
          src_fifo_rden = 1'b1;
          if (!src_fifo_empty) begin
            ref_wen    = 1'b1;
            ref_din    = src_fifo_data[WIDTH-1:0];
            load_cnt_d = load_cnt_q + AXIS_WIDTH'(1);
          end
        end
      end
      Q_INIT: begin
        // The datapath reset pulses only on the first cycle, even if we wait here for a query id.
        dp_rst        = init_first_q;
        init_first_d  = 1'b0;
        ref_addr_d    = '0;
        src_fifo_rden = 1'b1;
        if (!src_fifo_empty) begin
          qid_d      = src_fifo_data;
          samp_cnt_d = '0;
          state_d    = Q_RUN;
        end else if (!rs) begin
          state_d     = IDLE;
          load_done_d = 1'b0;
        end
      end
      Q_RUN: begin
        if (!run_tail) begin
          src_fifo_rden = 1'b1;
          if (!src_fifo_empty) begin
            dp_running = 1'b1;
            ref_addr_d = ref_addr_q + REFMEM_PTR_WIDTH'(1);
            samp_cnt_d = samp_cnt_q + SCW'(1);
          end
        end else begin
          // Drain phase: the datapath keeps walking the reference until it reports done.
          dp_running = 1'b1;
          ref_addr_d = ref_addr_q + REFMEM_PTR_WIDTH'(1);
          if (dp_done) begin
            state_d = Q_OUT;
            word_d  = 2'd0;
            pos_d   = dp_position;
            min_d   = dp_minval;
          end
        end
      end
      Q_OUT: begin
        if (!emit_rec) begin
          finish = 1'b1;
        end else begin
          case (word_q)
            2'd0:    sink_fifo_data = qid_q;
            2'd1:    sink_fifo_data = pos_q;
            default: sink_fifo_data = 32'(min_q);
          endcase
          sink_fifo_last = (word_q == 2'd2) && is_final;
          if (!sink_fifo_full) begin
            sink_fifo_wren = 1'b1;
            if (word_q == 2'd2) finish = 1'b1;
            else                word_d = word_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      n_done_d = n_done_inc;
      if (is_final) begin
        state_d     = IDLE;
        load_done_d = 1'b0;
      end else begin
        state_d      = Q_INIT;
        init_first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      ref_addr_q   <= '0;
      samp_cnt_q   <= '0;
      qid_q        <= '0;
      pos_q        <= '0;
      min_q        <= '0;
      word_q       <= '0;
      init_first_q <= 1'b0;
      load_done_q  <= 1'b0;
      n_done_q     <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      ref_addr_q   <= ref_addr_d;
      samp_cnt_q   <= samp_cnt_d;
      qid_q        <= qid_d;
      pos_q        <= pos_d;
      min_q        <= min_d;
      word_q       <= word_d;
      init_first_q <= init_first_d;
      load_done_q  <= load_done_d;
      n_done_q     <= n_done_d;
    end
  end

`ifdef DTW_THRESH_REJECT_EN
  logic        reject_q, reject_d;
  logic [31:0] n_reject_q, n_reject_d;

  assign emit_rec = ~reject_q;
  assign n_reject = n_reject_q;

  // The reject decision is taken from the minval presented alongside dp_done.
  always_comb begin
    reject_d   = reject_q;
    n_reject_d = n_reject_q;
    if ((state_q == IDLE) && rs) n_reject_d = '0;
    if ((state_q == Q_RUN) && run_tail && dp_done) reject_d = (dp_minval > threshold);
    if (finish && reject_q) n_reject_d = n_reject_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_q   <= 1'b0;
      n_reject_q <= '0;
    end else begin
      reject_q   <= reject_d;
      n_reject_q <= n_reject_d;
    end
  end
`else
  logic unused_thresh;

  assign unused_thresh = ^threshold;
  assign emit_rec      = 1'b1;
  assign n_reject      = '0;
`endif

endmodule

// File: tb/tb_dtw_core_batch.sv
// Self-checking bench for dtw_core_batch: randomized batches, a behavioural datapath and FIFOs,
// and a scoreboard that checks every reference write and sink word against a batch-level model.
module tb_dtw_core_batch;

  localparam int WIDTH = 16;
  localparam int AXIS_WIDTH = 32;
  localparam int SQG = 8;
  localparam int PTRW = 20;
  localparam int TAIL = 3;

  typedef struct {logic [31:0] data; logic last;} sink_t;
  typedef struct {logic [PTRW-1:0] addr; logic [WIDTH-1:0] din;} refw_t;
  typedef struct {logic [WIDTH-1:0] minv; logic [31:0] pos;} res_t;

  logic                  clk, rst_n, rs;
  logic [AXIS_WIDTH-1:0] ref_len;
  logic [31:0]           num_queries;
  logic [WIDTH-1:0]      threshold;
  logic                  busy, load_done;
  logic [31:0]           n_done, n_reject;
  logic                  src_fifo_clear, src_fifo_rden, src_fifo_empty;
  logic [31:0]           src_fifo_data;
  logic                  sink_fifo_wren, sink_fifo_full, sink_fifo_last;
  logic [31:0]           sink_fifo_data;
  logic                  ref_wen;
  logic [PTRW-1:0]       ref_addr;
  logic [WIDTH-1:0]      ref_din;
  logic                  dp_rst, dp_running, dp_done;
  logic [WIDTH-1:0]      dp_minval;
  logic [31:0]           dp_position;

  logic [31:0] srcQ[$];
  sink_t       expSink[$];
  refw_t       expRef[$];
  res_t        resQ[$];
  int          checks = 0;
  int          errors = 0;
  int          runCnt;
  int          sinkWrites = 0;
  int          fullMode = 0;
  int          fullCnt;
  int          fullBase;
  logic        srcHold = 1'b0;
  bit          srcFire;
  bit          resPending;
  sink_t       expS;
  refw_t       expR;

  dtw_core_batch #(
    .WIDTH(WIDTH), .AXIS_WIDTH(AXIS_WIDTH), .SQG_SIZE(SQG), .REFMEM_PTR_WIDTH(PTRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .ref_len(ref_len), .num_queries(num_queries),
    .threshold(threshold), .busy(busy), .load_done(load_done), .n_done(n_done),
    .n_reject(n_reject), .src_fifo_clear(src_fifo_clear), .src_fifo_rden(src_fifo_rden),
    .src_fifo_empty(src_fifo_empty), .src_fifo_data(src_fifo_data),
    .sink_fifo_wren(sink_fifo_wren), .sink_fifo_full(sink_fifo_full),
    .sink_fifo_data(sink_fifo_data), .sink_fifo_last(sink_fifo_last), .ref_wen(ref_wen),
    .ref_addr(ref_addr), .ref_din(ref_din), .dp_rst(dp_rst), .dp_running(dp_running),
    .dp_done(dp_done), .dp_minval(dp_minval), .dp_position(dp_position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Source FIFO (first-word-fall-through); consumption sampled mid-cycle, applied after the edge.
  initial begin
    src_fifo_empty = 1'b1;
    src_fifo_data  = '0;
    forever begin
      @(negedge clk);
      srcFire = src_fifo_rden && !src_fifo_empty;
      @(posedge clk);
      #3;
      if (srcFire && srcQ.size() > 0) void'(srcQ.pop_front());
      src_fifo_empty = srcHold || (srcQ.size() == 0);
      src_fifo_data  = (srcQ.size() > 0) ? srcQ[0] : 32'd0;
    end
  end

  // Sink back-pressure: off, random, or one 5-cycle stall after the first word of the batch.
  initial begin
    sink_fifo_full = 1'b0;
    fullCnt = 0;
    fullBase = 0;
    forever begin
      @(posedge clk);
      #2;
      case (fullMode)
        1: sink_fifo_full = ($urandom_range(0, 2) == 0);
        2: begin
          if (sinkWrites > fullBase && fullCnt < 5) begin
            sink_fifo_full = 1'b1;
            fullCnt++;
          end else begin
            sink_fifo_full = 1'b0;
          end
        end
        default: begin
          sink_fifo_full = 1'b0;
          fullCnt = 0;
          fullBase = sinkWrites;
        end
      endcase
    end
  end

  // Datapath model: signals done TAIL cycles after the last sample, reporting the queued result.
  initial begin
    dp_done = 1'b0;
    dp_minval = '0;
    dp_position = '0;
    runCnt = 0;
    resPending = 1'b0;
    forever begin
      @(negedge clk);
      if (dp_rst) begin
        runCnt = 0;
        if (resPending && resQ.size() > 0) void'(resQ.pop_front());
        resPending = 1'b0;
      end else if (dp_running) begin
        runCnt++;
      end
      dp_done = (runCnt >= SQG + TAIL);
      if (dp_done) resPending = 1'b1;
      dp_minval   = (resQ.size() > 0) ? resQ[0].minv : '0;
      dp_position = (resQ.size() > 0) ? resQ[0].pos : 32'd0;
    end
  end

  // Scoreboard monitor for reference writes and sink words.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ref_wen) begin
          checkOutput("ref_expected", expRef.size() > 0, 1);
          if (expRef.size() > 0) begin
            expR = expRef.pop_front();
            checkOutput("ref_addr", ref_addr, expR.addr);
            checkOutput("ref_din", ref_din, expR.din);
          end
        end
        if (sink_fifo_wren) begin
          sinkWrites++;
          checkOutput("wren_while_full", sink_fifo_full, 0);
          checkOutput("load_done_in_out", load_done, 1);
          checkOutput("sink_expected", expSink.size() > 0, 1);
          if (expSink.size() > 0) begin
            expS = expSink.pop_front();
            checkOutput("sink_data", sink_fifo_data, expS.data);
            checkOutput("sink_last", sink_fifo_last, expS.last);
          end
        end
      end
    end
  end

  // Reference model: builds the source stream, datapath results and expected outputs for a batch.
  task automatic applyStimulus(input int refLen, input int numQ, input int genQ,
                               input logic [WIDTH-1:0] thresh, input bit dirMin, input bit dirRef,
                               output int rejExp);
    logic [31:0] w;
    res_t r;
    sink_t s;
    refw_t rw;
    bit rej;
    rejExp = 0;
    ref_len = AXIS_WIDTH'(refLen);
    num_queries = 32'(numQ);
    threshold = thresh;
    for (int i = 0; i < refLen; i++) begin
      w = dirRef ? 32'(10 + i) : $urandom;
      srcQ.push_back(w);
      rw.addr = PTRW'(i);
      rw.din = w[WIDTH-1:0];
      expRef.push_back(rw);
    end
    for (int q = 0; q < genQ; q++) begin
      w = $urandom;
      srcQ.push_back(w);
      for (int k = 0; k < SQG; k++) srcQ.push_back($urandom);
      r.minv = dirMin ? ((q == 0) ? WIDTH'(50) : WIDTH'(150)) : WIDTH'($urandom_range(0, 300));
      r.pos = $urandom;
      resQ.push_back(r);
`ifdef DTW_THRESH_REJECT_EN
      rej = (r.minv > thresh);
`else
      rej = 1'b0;
`endif
      if (rej) begin
        rejExp++;
      end else begin
        s.last = 1'b0;
        s.data = w;
        expSink.push_back(s);
        s.data = r.pos;
        expSink.push_back(s);
        s.data = 32'(r.minv);
        s.last = (numQ != 0) && (q == genQ - 1);
        expSink.push_back(s);
      end
    end
  endtask

  task automatic startBatch();
    @(posedge clk); #2 rs = 1'b1;
    @(posedge clk); #2 rs = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitRunCnt(input int target, input string name);
    bit found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (runCnt == target) found = 1'b1;
    end
    checkOutput(name, found, 1);
  endtask

  task automatic runBatch(input int refLen, input int numQ, input int genQ,
                          input logic [WIDTH-1:0] thresh, input int fMode, input bit stallRun,
                          input bit dirMin, input bit dirRef);
    int rejExp;
    @(posedge clk); #2;
    applyStimulus(refLen, numQ, genQ, thresh, dirMin, dirRef, rejExp);
    fullMode = fMode;
    startBatch();
    if (stallRun) begin
      waitRunCnt(3, "stall_reach_run");
      @(posedge clk); #2 srcHold = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput("stall_dp_running", dp_running, 0);
        checkOutput("stall_ref_addr", ref_addr, 3);
      end
      @(posedge clk); #2 srcHold = 1'b0;
      @(negedge clk);
      checkOutput("resume_dp_running", dp_running, 1);
      checkOutput("resume_ref_addr", ref_addr, 3);
    end
    for (int c = 0; c < 3000 && busy; c++) @(negedge clk);
    checkOutput("batch_done", busy, 0);
    fullMode = 0;
    checkOutput("end_n_done", n_done, genQ);
    checkOutput("end_n_reject", n_reject, rejExp);
    checkOutput("end_load_done", load_done, 0);
    checkOutput("end_src_clear", src_fifo_clear, 1);
    checkOutput("end_dp_rst", dp_rst, 1);
    checkOutput("end_sink_left", expSink.size(), 0);
    checkOutput("end_ref_left", expRef.size(), 0);
    checkOutput("end_src_left", srcQ.size(), 0);
  endtask

  task automatic resetMidQuery();
    int rejExp;
    int savedWrites;
    @(posedge clk); #2;
    applyStimulus(2, 2, 2, '1, 1'b0, 1'b0, rejExp);
    startBatch();
    waitRunCnt(2, "rst_reach_run");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_src_clear", src_fifo_clear, 1);
    checkOutput("rst_dp_rst", dp_rst, 1);
    checkOutput("rst_dp_running", dp_running, 0);
    checkOutput("rst_rden", src_fifo_rden, 0);
    checkOutput("rst_wren", sink_fifo_wren, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_ref_addr", ref_addr, 0);
    savedWrites = sinkWrites;
    repeat (3) @(posedge clk);
    #2;
    srcQ.delete();
    expSink.delete();
    expRef.delete();
    resQ.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_no_sink_write", sinkWrites, savedWrites);
    checkOutput("rst_idle_after", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rs = 1'b0;
    ref_len = '0;
    num_queries = '0;
    threshold = '0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_load_done", load_done, 0);
    checkOutput("reset_src_clear", src_fifo_clear, 1);
    checkOutput("reset_dp_rst", dp_rst, 1);
    checkOutput("reset_rden", src_fifo_rden, 0);
    checkOutput("reset_wren", sink_fifo_wren, 0);
    checkOutput("reset_ref_wen", ref_wen, 0);
    checkOutput("reset_dp_running", dp_running, 0);
    checkOutput("reset_n_done", n_done, 0);
    checkOutput("reset_n_reject", n_reject, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    runBatch(4, 2, 2, '1, 0, 1'b0, 1'b0, 1'b1);
    runBatch(3, 3, 3, '1, 2, 1'b0, 1'b0, 1'b0);
    runBatch(2, 1, 1, '1, 0, 1'b1, 1'b0, 1'b0);
    runBatch(0, 2, 2, WIDTH'(100), 0, 1'b0, 1'b1, 1'b0);
    runBatch(5, 0, 3, WIDTH'(150), 1, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++)
      runBatch($urandom_range(0, 6), $urandom_range(1, 3) , 0, WIDTH'($urandom_range(0, 300)),
               1, 1'b0, 1'b0, 1'b0);
    resetMidQuery();
    runBatch(2, 1, 1, '1, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dtw_core_batch.md
DTW_CORE_BATCH -- requirements
Module: dtw_core_batch

Interface
REQ-001 SHALL provide parameters: WIDTH, default 16, sample/cost width; AXIS_WIDTH, default 32, stream word width; SQG_SIZE, default 256, samples per query; REFMEM_PTR_WIDTH, default 20, reference address width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL provide: rs  in  1  start; ref_len  in  AXIS_WIDTH  reference length in samples; num_queries  in  32  batch size, 0 = unbounded; threshold  in  WIDTH  reject limit.
REQ-004 SHALL provide: busy  out  1  not IDLE; load_done  out  1  reference resident; n_done  out  32  queries completed; n_reject  out  32  queries rejected.
REQ-005 SHALL provide the source interface: src_fifo_clear  out  1; src_fifo_rden  out  1; src_fifo_empty  in  1; src_fifo_data  in  32.
REQ-006 SHALL provide the sink interface: sink_fifo_wren  out  1; sink_fifo_full  in  1; sink_fifo_data  out  32; sink_fifo_last  out  1.
REQ-007 SHALL provide the reference-memory port: ref_wen  out  1; ref_addr  out  REFMEM_PTR_WIDTH; ref_din  out  WIDTH.
REQ-008 SHALL provide the datapath port: dp_rst  out  1; dp_running  out  1; dp_done  in  1; dp_minval  in  WIDTH; dp_position  in  32.

Function
REQ-009 Source FIFO is first-word-fall-through; a word SHALL be consumed only in cycles with src_fifo_rden=1 and src_fifo_empty=0, and src_fifo_rden SHALL be 0 in every state that does not consume.
REQ-010 States SHALL be IDLE, REF_LOAD, Q_INIT, Q_RUN, Q_OUT; IDLE SHALL go to REF_LOAD when rs=1.
REQ-011 In IDLE: src_fifo_clear=1, dp_rst=1, busy=0, load_done=0; n_done and n_reject SHALL clear on the IDLE->REF_LOAD transition.
REQ-012 In REF_LOAD, each consumed word SHALL write ref_din=src_fifo_data[WIDTH-1:0] at ref_addr=load count with ref_wen=1 in the same cycle, and the count SHALL then increment.
REQ-013 When the load count equals ref_len (including ref_len=0), the block SHALL set load_done=1 and go to Q_INIT without further reads.
REQ-014 Each entry to Q_INIT SHALL assert dp_rst for exactly one cycle, clearing the datapath between queries, and SHALL zero ref_addr.
REQ-015 Q_INIT SHALL consume one word as the query id (held 32-bit) and then go to Q_RUN.
REQ-016 In Q_INIT with src_fifo_empty=1 and rs=0, the block SHALL return to IDLE; this is the only exit from an unbounded batch.
REQ-017 Q_RUN SHALL consume SQG_SIZE samples; dp_running=1 and ref_addr+1 only in cycles where a sample is consumed; an empty FIFO SHALL stall with dp_running=0.
REQ-018 After SQG_SIZE samples, Q_RUN SHALL hold dp_running=1, increment ref_addr every cycle, read no more words, and go to Q_OUT on dp_done=1.
REQ-019 Q_OUT SHALL emit three words: qid, dp_position, then dp_minval zero-extended to 32 bits.
REQ-020 Q_OUT SHALL assert sink_fifo_wren only in cycles with sink_fifo_full=0, advancing one word per write; full SHALL stall with wren=0 and the data held.
REQ-021 sink_fifo_last SHALL be 1 only with the third word of the final query (n_done+1==num_queries, num_queries≠0).
REQ-022 After Q_OUT, n_done SHALL increment (wrapping at 2^32); the next state SHALL be IDLE, clearing load_done, if num_queries≠0 and n_done==num_queries, else Q_INIT with the reference retained.

Reset
REQ-023 rst_n=0 SHALL force IDLE immediately, regardless of clk.
REQ-024 During reset, every output SHALL be 0 except src_fifo_clear=1 and dp_rst=1; reset mid-query SHALL discard partial records.

Configuration
REQ-025 With macro DTW_THRESH_REJECT_EN defined, a query with dp_minval > threshold SHALL emit no words, SHALL increment n_reject and n_done, and, if final, SHALL emit no last.
REQ-026 Without DTW_THRESH_REJECT_EN, threshold SHALL be ignored, every query SHALL emit its record, and n_reject SHALL be constant 0.

Verification
REQ-027 ref_len=4, words 10..13 -> ref_wen at addr 0..3 with din 10..13, then load_done=1.
REQ-028 num_queries=2, SQG_SIZE samples per query, dp_done pulsed -> 6 sink words; last only on word 6; load_done 1->0 on IDLE return.
REQ-029 sink_fifo_full held 5 cycles mid-record -> no wren while full; record order and values intact.
REQ-030 src_fifo_empty for 3 cycles in Q_RUN -> dp_running=0 for exactly those cycles; ref_addr frozen.
REQ-031 DTW_THRESH_REJECT_EN, threshold=100, minvals 50,150 -> one record, n_reject=1, n_done=2.
REQ-032 rst_n low during Q_RUN -> asynchronous return to IDLE, src_fifo_clear=1, no sink write.
